// File: rtl/bus_arbiter_4ch.sv
// ---------------------------------------------------------------------------
// bus_arbiter_4ch
//
// Round-robin arbiter and sequencer for the shared 4-channel 32-bit datapath
// mux. One requester at a time owns the downstream bus port. The grant is
// held until the slave acknowledges or the requester withdraws, and the
// winner gets a one-cycle completion pulse.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> 16-bit watchdog aborts a transfer after TIMEOUT BUSY cycles
//                without bus_ack and pulses err on the owning channel.
//   undefined -> no watchdog; BUSY waits for bus_ack or a req drop and err
//                is tied to zero.
//
// Parameters:
//   TIMEOUT    BUSY cycles without bus_ack before abort (1..65535).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req[3:0]   in   per-channel request, held until done/err
//   bus_ack    in   slave acknowledge, completes the current transfer
//   grant[3:0] out  registered one-hot grant, zero when idle
//   sel[1:0]   out  registered mux select, index of the granted channel
//   bus_valid  out  high while a grant is active
//   done[3:0]  out  one-cycle pulse on the channel whose transfer was acked
//   err[3:0]   out  one-cycle pulse on the channel whose transfer timed out
// ---------------------------------------------------------------------------
module bus_arbiter_4ch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       bus_ack,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       bus_valid,
    output logic [3:0] done,
    output logic [3:0] err
);

    // Out-of-range TIMEOUT would silently truncate in the 16-bit counter.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bus_arbiter_4ch: TIMEOUT must be in 1..65535");
    end

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [3:0] done_q, done_d;
    logic [1:0] ptr_q, ptr_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  err_q, err_d;
`endif

    // Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr (mod 4).
    logic       pick_found;
    logic [1:0] pick_idx;

    always_comb begin
        logic [1:0] cand;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + k[1:0];
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        done_d  = '0;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = '0;
`endif

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = 4'b0001 << pick_idx;
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    state_d = StBusy;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            StBusy: begin
                // Priority: ack, then requester withdrawal, then watchdog.
                // sel is left untouched on release so the mux input does not
                // change until the next grant.
                if (bus_ack) begin
                    done_d  = 4'b0001 << sel_q;
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q;
                    state_d = StIdle;
                end else if (!req[sel_q]) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q;
                    state_d = StIdle;
                end
`ifdef ARB_TIMEOUT_EN
                // cnt_q counts completed BUSY cycles; the TIMEOUT-th cycle
                // without ack is the one where cnt_q == TIMEOUT-1.
                else if (cnt_q == TimeoutLast) begin
                    err_d   = 4'b0001 << sel_q;
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= '0;
            ptr_q   <= 2'd3;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign bus_valid = valid_q;
    assign done      = done_q;
`ifdef ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = '0;
`endif

    a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_q));
    a_done_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(done_q));
    a_done_err_excl : assert property (@(posedge clk) disable iff (reset)
        !(|done_q && |err));

endmodule

// File: tb/tb_bus_arbiter_4ch.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_4ch
//
// Directed bench for bus_arbiter_4ch: reset state, single transfer,
// round-robin fairness, pointer rotation, abandon, ack/drop race, watchdog
// (or indefinite hold without ARB_TIMEOUT_EN) and reset during BUSY.
// Inputs change 1 time unit after each rising edge; outputs are checked at
// that same point, i.e. reflecting the edge just taken.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_4ch;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       bus_ack;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       bus_valid;
    logic [3:0] done;
    logic [3:0] err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    bus_arbiter_4ch #(
        .TIMEOUT(8)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .bus_ack  (bus_ack),
        .grant    (grant),
        .sel      (sel),
        .bus_valid(bus_valid),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares all outputs packed as {grant, sel, bus_valid, done, err}.
    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic [3:0] d, input logic [3:0] e);
        check(tag, {17'd0, grant, sel, bus_valid, done, err}, {17'd0, g, s, v, d, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = 4'b0000;
        bus_ack = 1'b0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
    endtask

    initial begin
        req     = 4'b0000;
        bus_ack = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        chk_out("reset_state", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);
        tick();
        chk_out("idle_no_req", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);

        // Single request, ack three cycles after the grant.
        req = 4'b0001;
        tick();
        chk_out("single_grant", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);
        tick();
        tick();
        chk_out("single_hold", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);
        bus_ack = 1'b1;
        tick();
        chk_out("single_done", 4'b0000, 2'd0, 1'b0, 4'b0001, 4'b0000);
        bus_ack = 1'b0;
        req     = 4'b0000;
        tick();
        chk_out("single_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);

        // Fairness: all requesting, ack in first BUSY cycle -> 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            logic [1:0] ch;
            ch = 2'(i % 4);
            chk_out($sformatf("fair_grant%0d", i), 4'b0001 << ch, ch, 1'b1, 4'b0000, 4'b0000);
            bus_ack = 1'b1;
            tick();
            chk_out($sformatf("fair_done%0d", i), 4'b0000, ch, 1'b0, 4'b0001 << ch, 4'b0000);
            bus_ack = 1'b0;
            tick();
        end

        // Pointer rotation.
        do_reset();
        req = 4'b0001;
        tick();
        chk_out("rot_ch0", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        req     = 4'b0101;
        tick();
        chk_out("rot_ch2", 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000);
        bus_ack = 1'b1;
        tick();
        chk_out("rot_ch2_done", 4'b0000, 2'd2, 1'b0, 4'b0100, 4'b0000);
        bus_ack = 1'b0;
        tick();
        chk_out("rot_back_ch0", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        req     = 4'b0000;
        tick();

        // Abandon: ch1 drops its request without ack.
        do_reset();
        req = 4'b0010;
        tick();
        chk_out("abn_grant", 4'b0010, 2'd1, 1'b1, 4'b0000, 4'b0000);
        tick();
        tick();
        req = 4'b0000;
        tick();
        chk_out("abn_release", 4'b0000, 2'd1, 1'b0, 4'b0000, 4'b0000);
        req = 4'b0011;
        tick();
        chk_out("abn_next_ch0", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);
        // Ack ch0 while it drops; ch1 stays requesting.
        bus_ack = 1'b1;
        req     = 4'b0010;
        tick();
        chk_out("abn_ch0_done", 4'b0000, 2'd0, 1'b0, 4'b0001, 4'b0000);
        bus_ack = 1'b0;
        tick();
        chk_out("abn_ch1_grant", 4'b0010, 2'd1, 1'b1, 4'b0000, 4'b0000);
        // Ack and request drop in the same cycle: ack wins.
        bus_ack = 1'b1;
        req     = 4'b0000;
        tick();
        chk_out("race_done", 4'b0000, 2'd1, 1'b0, 4'b0010, 4'b0000);
        bus_ack = 1'b0;
        tick();
        chk_out("race_idle", 4'b0000, 2'd1, 1'b0, 4'b0000, 4'b0000);

        // Watchdog on ch3 (TIMEOUT = 8).
        do_reset();
        req = 4'b1000;
        tick();
        chk_out("to_grant", 4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000);
`ifdef ARB_TIMEOUT_EN
        repeat (7) tick();
        chk_out("to_hold7", 4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000);
        tick();
        chk_out("to_err", 4'b0000, 2'd3, 1'b0, 4'b0000, 4'b1000);
        req = 4'b0000;
        tick();
        chk_out("to_err_pulse", 4'b0000, 2'd3, 1'b0, 4'b0000, 4'b0000);
`else
        repeat (100) tick();
        chk_out("to_hold100", 4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000);
        bus_ack = 1'b1;
        tick();
        chk_out("to_late_done", 4'b0000, 2'd3, 1'b0, 4'b1000, 4'b0000);
        bus_ack = 1'b0;
        req     = 4'b0000;
        tick();
`endif

        // Reset while ch2 is BUSY.
        do_reset();
        req = 4'b0100;
        tick();
        chk_out("rst_busy_grant", 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000);
        tick();
        reset = 1'b1;
        tick();
        chk_out("rst_busy_cleared", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        chk_out("rst_after_ch0", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
